// File: rtl/sal_cmd_sched.sv
// -----------------------------------------------------------------------------
// sal_cmd_sched
//
// This block is the command-bus scheduler for NUM_BANKS per-bank controllers.
// Each cycle it grants at most one command across all banks and command types.
// Grants are combinational and answer requests in the same cycle. The issued
// command and its fields are registered and appear one cycle after the grant.
//
// Class priority, from highest to lowest:
//   column (RD/WR), then ACT, then PRE, then REF.
// Each class picks its winning bank round-robin from its own pointer.
// A bank that asserts several request types is considered only in its
// highest-priority visible class. Within the column class, a bank that asserts
// both RD and WR is granted its RD.
//
// Handshake: a requester holds its *_req_i bit high until it sees the matching
// *_gnt_o bit high in the same cycle. Nothing changes for requests that are not
// granted.
//
// Optional feature (macro SAL_FAW_CHECK_EN):
//   Adds four tFAW down-counters. Each ACT grant loads one counter that is at
//   zero. While all four counters are nonzero, the ACT class is hidden, so a
//   bank's PRE/REF request can compete during that window.
//   Without the macro, t_faw_m1_i is ignored and ACT is never masked.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   act/rd/wr/pre/ref_req_i    per-bank requests        [NUM_BANKS]
//   ra_i/ca_i/id_i/len_i       per-bank fields, bank b at slice b
//   t_faw_m1_i                 tFAW - 1, quasi-static
//   act/rd/wr/pre/ref_gnt_o    per-bank grants (one-hot or zero overall)
//   cmd_o                      0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
//   ba_o, ra_o, ca_o, id_o, len_o  registered fields of the issued command
// -----------------------------------------------------------------------------
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_FAW_WIDTH
`define T_FAW_WIDTH 6
`endif

module sal_cmd_sched #(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_BANKS-1:0]                   act_req_i,
  input  logic [NUM_BANKS-1:0]                   rd_req_i,
  input  logic [NUM_BANKS-1:0]                   wr_req_i,
  input  logic [NUM_BANKS-1:0]                   pre_req_i,
  input  logic [NUM_BANKS-1:0]                   ref_req_i,
  input  logic [NUM_BANKS*`DRAM_RA_WIDTH-1:0]    ra_i,
  input  logic [NUM_BANKS*`DRAM_CA_WIDTH-1:0]    ca_i,
  input  logic [NUM_BANKS*`AXI_ID_WIDTH-1:0]     id_i,
  input  logic [NUM_BANKS*`AXI_LEN_WIDTH-1:0]    len_i,
  input  logic [`T_FAW_WIDTH-1:0]                t_faw_m1_i,
  output logic [NUM_BANKS-1:0]                   act_gnt_o,
  output logic [NUM_BANKS-1:0]                   rd_gnt_o,
  output logic [NUM_BANKS-1:0]                   wr_gnt_o,
  output logic [NUM_BANKS-1:0]                   pre_gnt_o,
  output logic [NUM_BANKS-1:0]                   ref_gnt_o,
  output logic [2:0]                             cmd_o,
  output logic [BA_W-1:0]                        ba_o,
  output logic [`DRAM_RA_WIDTH-1:0]              ra_o,
  output logic [`DRAM_CA_WIDTH-1:0]              ca_o,
  output logic [`AXI_ID_WIDTH-1:0]               id_o,
  output logic [`AXI_LEN_WIDTH-1:0]              len_o
);

  localparam int RA_W  = `DRAM_RA_WIDTH;
  localparam int CA_W  = `DRAM_CA_WIDTH;
  localparam int ID_W  = `AXI_ID_WIDTH;
  localparam int LEN_W = `AXI_LEN_WIDTH;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Round-robin pick. This returns {found, bank}. The first requesting bank
  // at or above ptr wins, with wrap-around. NUM_BANKS is a power of two, so
  // the BA_W-bit addition wraps naturally.
  function automatic logic [BA_W:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                            input logic [BA_W-1:0]      ptr);
    logic [BA_W-1:0] idx;
    logic            found;
    logic [BA_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      idx = ptr + BA_W'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  logic [BA_W-1:0] r_col_ptr, r_act_ptr, r_pre_ptr, r_ref_ptr;

  logic [2:0]       r_cmd;
  logic [BA_W-1:0]  r_ba;
  logic [RA_W-1:0]  r_ra;
  logic [CA_W-1:0]  r_ca;
  logic [ID_W-1:0]  r_id;
  logic [LEN_W-1:0] r_len;

  logic                 w_act_mask;
  logic [NUM_BANKS-1:0] w_col_req, w_act_vis;
  logic [NUM_BANKS-1:0] w_act_elig, w_pre_elig, w_ref_elig;
  logic [BA_W:0]        w_col_pick, w_act_pick, w_pre_pick, w_ref_pick;

  // The ACT mask is applied before class filtering. A bank whose ACT is held
  // back by tFAW can therefore still have its PRE or REF considered.
  assign w_col_req  = rd_req_i | wr_req_i;
  assign w_act_vis  = act_req_i & {NUM_BANKS{~w_act_mask}};
  assign w_act_elig = w_act_vis & ~w_col_req;
  assign w_pre_elig = pre_req_i & ~w_col_req & ~w_act_vis;
  assign w_ref_elig = ref_req_i & ~w_col_req & ~w_act_vis & ~pre_req_i;

  assign w_col_pick = rr_pick(w_col_req,  r_col_ptr);
  assign w_act_pick = rr_pick(w_act_elig, r_act_ptr);
  assign w_pre_pick = rr_pick(w_pre_elig, r_pre_ptr);
  assign w_ref_pick = rr_pick(w_ref_elig, r_ref_ptr);

  logic [2:0]       w_cmd_nxt;
  logic [BA_W-1:0]  w_win;
  logic [RA_W-1:0]  w_ra_nxt;
  logic [CA_W-1:0]  w_ca_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic [LEN_W-1:0] w_len_nxt;

  always_comb begin
    act_gnt_o = '0;
    rd_gnt_o  = '0;
    wr_gnt_o  = '0;
    pre_gnt_o = '0;
    ref_gnt_o = '0;
    w_cmd_nxt = CMD_NOP;
    w_win     = '0;
    w_ra_nxt  = '0;
    w_ca_nxt  = '0;
    w_id_nxt  = '0;
    w_len_nxt = '0;
    // Grants are held at zero while reset is asserted.
    if (rst_n) begin
      if (w_col_pick[BA_W]) begin
        w_win     = w_col_pick[BA_W-1:0];
        w_ca_nxt  = ca_i[w_win*CA_W +: CA_W];
        w_id_nxt  = id_i[w_win*ID_W +: ID_W];
        w_len_nxt = len_i[w_win*LEN_W +: LEN_W];
        if (rd_req_i[w_win]) begin
          rd_gnt_o[w_win] = 1'b1;
          w_cmd_nxt       = CMD_RD;
        end else begin
          wr_gnt_o[w_win] = 1'b1;
          w_cmd_nxt       = CMD_WR;
        end
      end else if (w_act_pick[BA_W]) begin
        w_win            = w_act_pick[BA_W-1:0];
        act_gnt_o[w_win] = 1'b1;
        w_cmd_nxt        = CMD_ACT;
        w_ra_nxt         = ra_i[w_win*RA_W +: RA_W];
      end else if (w_pre_pick[BA_W]) begin
        w_win            = w_pre_pick[BA_W-1:0];
        pre_gnt_o[w_win] = 1'b1;
        w_cmd_nxt        = CMD_PRE;
      end else if (w_ref_pick[BA_W]) begin
        w_win            = w_ref_pick[BA_W-1:0];
        ref_gnt_o[w_win] = 1'b1;
        w_cmd_nxt        = CMD_REF;
      end
    end
  end

  // Only the pointer of the class that was granted advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_ptr <= '0;
      r_act_ptr <= '0;
      r_pre_ptr <= '0;
      r_ref_ptr <= '0;
    end else begin
      if (w_cmd_nxt == CMD_RD || w_cmd_nxt == CMD_WR) r_col_ptr <= w_win + 1'b1;
      if (w_cmd_nxt == CMD_ACT)                       r_act_ptr <= w_win + 1'b1;
      if (w_cmd_nxt == CMD_PRE)                       r_pre_ptr <= w_win + 1'b1;
      if (w_cmd_nxt == CMD_REF)                       r_ref_ptr <= w_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= CMD_NOP;
      r_ba  <= '0;
      r_ra  <= '0;
      r_ca  <= '0;
      r_id  <= '0;
      r_len <= '0;
    end else begin
      r_cmd <= w_cmd_nxt;
      r_ba  <= w_win;
      r_ra  <= w_ra_nxt;
      r_ca  <= w_ca_nxt;
      r_id  <= w_id_nxt;
      r_len <= w_len_nxt;
    end
  end

  assign cmd_o = r_cmd;
  assign ba_o  = r_ba;
  assign ra_o  = r_ra;
  assign ca_o  = r_ca;
  assign id_o  = r_id;
  assign len_o = r_len;

`ifdef SAL_FAW_CHECK_EN
  localparam int FAW_W = `T_FAW_WIDTH;

  logic [FAW_W-1:0] r_faw_cnt [4];
  logic [3:0]       w_faw_zero;
  logic [3:0]       w_faw_load;

  always_comb begin
    for (int k = 0; k < 4; k++) w_faw_zero[k] = (r_faw_cnt[k] == '0);
  end

  // The lowest-numbered idle counter takes the new ACT. One is always idle
  // when an ACT is granted, because ACT is masked otherwise.
  always_comb begin
    w_faw_load = '0;
    if (w_faw_zero[0])      w_faw_load[0] = 1'b1;
    else if (w_faw_zero[1]) w_faw_load[1] = 1'b1;
    else if (w_faw_zero[2]) w_faw_load[2] = 1'b1;
    else if (w_faw_zero[3]) w_faw_load[3] = 1'b1;
  end

  assign w_act_mask = ~|w_faw_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) r_faw_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_cmd_nxt == CMD_ACT && w_faw_load[k]) r_faw_cnt[k] <= t_faw_m1_i;
        else if (!w_faw_zero[k])                   r_faw_cnt[k] <= r_faw_cnt[k] - 1'b1;
      end
    end
  end
`else
  logic w_unused_faw;
  assign w_unused_faw = ^t_faw_m1_i;
  assign w_act_mask   = 1'b0;
`endif

endmodule

// File: tb/tb_sal_cmd_sched.sv
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef T_FAW_WIDTH
`define T_FAW_WIDTH 6
`endif

module tb_sal_cmd_sched;
  localparam int NB    = 4;
  localparam int BA_W  = 2;
  localparam int RA_W  = `DRAM_RA_WIDTH;
  localparam int CA_W  = `DRAM_CA_WIDTH;
  localparam int ID_W  = `AXI_ID_WIDTH;
  localparam int LEN_W = `AXI_LEN_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB*RA_W-1:0]  ra_i;
  logic [NB*CA_W-1:0]  ca_i;
  logic [NB*ID_W-1:0]  id_i;
  logic [NB*LEN_W-1:0] len_i;
  logic [`T_FAW_WIDTH-1:0] t_faw_m1;
  logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [2:0]       cmd_o;
  logic [BA_W-1:0]  ba_o;
  logic [RA_W-1:0]  ra_o;
  logic [CA_W-1:0]  ca_o;
  logic [ID_W-1:0]  id_o;
  logic [LEN_W-1:0] len_o;

  int n_checks = 0;
  int n_fail   = 0;

  sal_cmd_sched #(.NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra_i), .ca_i(ca_i), .id_i(id_i), .len_i(len_i),
    .t_faw_m1_i(t_faw_m1),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .cmd_o(cmd_o), .ba_o(ba_o), .ra_o(ra_o), .ca_o(ca_o),
    .id_o(id_o), .len_o(len_o)
  );

  // per-bank field values, distinct for every bank
  function automatic logic [RA_W-1:0] ra_val(input int b);
    return RA_W'(32'h1234 + b * 32'h1111);
  endfunction
  function automatic logic [CA_W-1:0] ca_val(input int b);
    return CA_W'(32'h0A1 + b * 32'h013);
  endfunction
  function automatic logic [ID_W-1:0] id_val(input int b);
    return ID_W'(b + 5);
  endfunction
  function automatic logic [LEN_W-1:0] len_val(input int b);
    return LEN_W'(32'h10 + b * 7);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    act_req = 4'b1111;
    rd_req  = 4'b0001;
    #1;
    n_checks++;
    if ({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_gnt: grants=%b required 0", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt});
    end
    tick();
    n_checks++;
    if ({cmd_o, ba_o, ra_o, ca_o, id_o, len_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: cmd=%0d ba=%0d ra=%h ca=%h id=%h len=%h required all 0",
               cmd_o, ba_o, ra_o, ca_o, id_o, len_o);
    end
    clear_reqs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_priority();
    do_reset();
    rd_req  = 4'b0001;
    act_req = 4'b0010;
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0001 || act_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_gnt: rd_gnt=%b act_gnt=%b required 0001 0000", rd_gnt, act_gnt);
    end
    tick();
    n_checks++;
    if (cmd_o !== 3'd2 || ba_o !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_cmd: cmd=%0d ba=%0d required 2 0", cmd_o, ba_o);
    end
    n_checks++;
    if (ca_o !== ca_val(0) || id_o !== id_val(0) || len_o !== len_val(0) || ra_o !== '0) begin
      n_fail++;
      $display("FAIL prio_fields: ca=%h id=%h len=%h ra=%h required %h %h %h 0",
               ca_o, id_o, len_o, ra_o, ca_val(0), id_val(0), len_val(0));
    end
    // act bank 1 still pending and ACT pointer is 0, so bank 1 wins now
    rd_req = '0;
    #1;
    n_checks++;
    if (act_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_act_after: act_gnt=%b required 0010", act_gnt);
    end
    tick();
    clear_reqs();
    tick();
    n_checks++;
    if (cmd_o !== 3'd0) begin
      n_fail++;
      $display("FAIL nop_after_idle: cmd=%0d required 0", cmd_o);
    end
  endtask

  task automatic test_act_rr();
    logic [NB-1:0] exp_g;
    do_reset();
    act_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = NB'(1) << (i % 4);
      #1;
      n_checks++;
      if (act_gnt !== exp_g) begin
        n_fail++;
        $display("FAIL act_rr_gnt[%0d]: act_gnt=%b required %b", i, act_gnt, exp_g);
      end
      tick();
      n_checks++;
      if (cmd_o !== 3'd1 || ba_o !== BA_W'(i % 4) || ra_o !== ra_val(i % 4) || ca_o !== '0) begin
        n_fail++;
        $display("FAIL act_rr_out[%0d]: cmd=%0d ba=%0d ra=%h ca=%h required 1 %0d %h 0",
                 i, cmd_o, ba_o, ra_o, ca_o, i % 4, ra_val(i % 4));
      end
    end
    clear_reqs();
  endtask

  task automatic test_wr_pre();
    do_reset();
    wr_req  = 4'b0100;
    pre_req = 4'b0100;
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0100 || pre_gnt !== 4'b0000 || rd_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_pre_gnt: wr=%b pre=%b rd=%b required 0100 0000 0000", wr_gnt, pre_gnt, rd_gnt);
    end
    tick();
    n_checks++;
    if (cmd_o !== 3'd3 || ba_o !== 2'd2 || ca_o !== ca_val(2) || id_o !== id_val(2) ||
        len_o !== len_val(2) || ra_o !== '0) begin
      n_fail++;
      $display("FAIL wr_pre_out: cmd=%0d ba=%0d ca=%h id=%h len=%h ra=%h required 3 2 %h %h %h 0",
               cmd_o, ba_o, ca_o, id_o, len_o, ra_o, ca_val(2), id_val(2), len_val(2));
    end
    clear_reqs();
  endtask

  task automatic test_pre_ref();
    do_reset();
    pre_req = 4'b0101;
    ref_req = 4'b1000;
    #1;
    n_checks++;
    if (pre_gnt !== 4'b0001 || ref_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL pre_first: pre=%b ref=%b required 0001 0000", pre_gnt, ref_gnt);
    end
    tick();
    n_checks++;
    if (cmd_o !== 3'd4 || ba_o !== 2'd0 || {ra_o, ca_o, id_o, len_o} !== '0) begin
      n_fail++;
      $display("FAIL pre_out: cmd=%0d ba=%0d ra=%h ca=%h required 4 0 0 0", cmd_o, ba_o, ra_o, ca_o);
    end
    pre_req = 4'b0100;
    #1;
    n_checks++;
    if (pre_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL pre_second: pre=%b required 0100", pre_gnt);
    end
    tick();
    pre_req = '0;
    #1;
    n_checks++;
    if (ref_gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL ref_gnt: ref=%b required 1000", ref_gnt);
    end
    tick();
    n_checks++;
    if (cmd_o !== 3'd5 || ba_o !== 2'd3 || {ra_o, ca_o, id_o, len_o} !== '0) begin
      n_fail++;
      $display("FAIL ref_out: cmd=%0d ba=%0d required 5 3, fields 0", cmd_o, ba_o);
    end
    clear_reqs();
  endtask

  task automatic test_rr_wrap();
    do_reset();
    rd_req = 4'b0010;
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_first: rd=%b required 0010", rd_gnt);
    end
    tick();
    rd_req = 4'b0011;
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second: rd=%b required 0001", rd_gnt);
    end
    tick();
    rd_req  = '0;
    act_req = 4'b1111;
    #1;
    n_checks++;
    if (act_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL act_ptr_hold: act=%b required 0001", act_gnt);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    act_req = 4'b1111;
    #1;
    n_checks++;
    if (act_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_act: act=%b required 0001", act_gnt);
    end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cmd_o !== 3'd0 || act_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_out: cmd=%0d act=%b required 0 0000", cmd_o, act_gnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_o !== 3'd0 || act_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_release: cmd=%0d act=%b required 0 0001", cmd_o, act_gnt);
    end
    tick();
    n_checks++;
    if (cmd_o !== 3'd1 || ba_o !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_next_act: cmd=%0d ba=%0d required 1 0", cmd_o, ba_o);
    end
    clear_reqs();
  endtask

  task automatic test_faw();
    logic [NB-1:0] exp_a, exp_p;
    do_reset();
    t_faw_m1 = 9;
    act_req  = 4'b1111;
`ifdef SAL_FAW_CHECK_EN
    for (int c = 0; c <= 10; c++) begin
      pre_req = (c == 5) ? 4'b0001 : 4'b0000;
      exp_a = (c < 4) ? NB'(1) << c : (c == 10) ? 4'b0001 : 4'b0000;
      exp_p = (c == 5) ? 4'b0001 : 4'b0000;
      #1;
      n_checks++;
      if (act_gnt !== exp_a || pre_gnt !== exp_p) begin
        n_fail++;
        $display("FAIL faw_cyc[%0d]: act=%b pre=%b required %b %b", c, act_gnt, pre_gnt, exp_a, exp_p);
      end
      tick();
      if (c == 5) begin
        n_checks++;
        if (cmd_o !== 3'd4 || ba_o !== 2'd0) begin
          n_fail++;
          $display("FAIL faw_pre_out: cmd=%0d ba=%0d required 4 0", cmd_o, ba_o);
        end
      end
    end
`else
    exp_p = '0;
    for (int c = 0; c < 6; c++) begin
      exp_a = NB'(1) << (c % 4);
      #1;
      n_checks++;
      if (act_gnt !== exp_a || pre_gnt !== exp_p) begin
        n_fail++;
        $display("FAIL nofaw_cyc[%0d]: act=%b pre=%b required %b %b", c, act_gnt, pre_gnt, exp_a, exp_p);
      end
      tick();
    end
`endif
    clear_reqs();
    t_faw_m1 = '0;
  endtask

  initial begin
    rst_n    = 1'b0;
    t_faw_m1 = '0;
    clear_reqs();
    for (int b = 0; b < NB; b++) begin
      ra_i[b*RA_W +: RA_W]    = ra_val(b);
      ca_i[b*CA_W +: CA_W]    = ca_val(b);
      id_i[b*ID_W +: ID_W]    = id_val(b);
      len_i[b*LEN_W +: LEN_W] = len_val(b);
    end
    tick();
    test_reset();
    test_priority();
    test_act_rr();
    test_wr_pre();
    test_pre_ref();
    test_rr_wrap();
    test_reset_mid();
    test_faw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
